// File: rtl/risc_controller.sv
// ---------------------------------------------------------------------------
// risc_controller
//   Instruction-sequencing FSM for the 8-bit accumulator CPU. Every
//   instruction walks through eight phases: fetch the instruction, load it
//   into the IR, then fetch the operand, run the ALU and store the result.
//   The IDLE phase can be stretched to give the memory time to settle. The
//   ALU decodes the opcode itself. This block only emits the datapath
//   strobes around it.
//
// Parameters
//   WAIT_CYCLES  cycles spent in IDLE (memory settle), legal range 1..15
//
// Configuration macro
//   RISC_CONTROLLER_RESUME_EN  adds the resume input. Without it, HLT is
//                              sticky until rst_ is asserted.
//
// Ports
//   clk     in   rising-edge clock
//   rst_    in   asynchronous active-low reset
//   opcode  in   IR[7:5]: HLT SKZ ADD AND XOR LDA STO JMP
//   zero    in   ALU a_is_zero (accumulator == 0)
//   resume  in   (RESUME_EN only) leave the halted state, sync, active-high
//   sel     out  address mux: 1 = PC, 0 = IR operand field
//   rd      out  memory read enable
//   ld_ir   out  load instruction register
//   inc_pc  out  increment program counter
//   halt    out  processor halted
//   ld_pc   out  load PC from IR operand (jump)
//   data_e  out  drive accumulator onto the data bus
//   ld_ac   out  load accumulator from alu_out
//   wr      out  memory write strobe
// ---------------------------------------------------------------------------
module risc_controller #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst_,
    input  logic [2:0] opcode,
    input  logic       zero,
`ifdef RISC_CONTROLLER_RESUME_EN
    input  logic       resume,
`endif
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       halt,
    output logic       ld_pc,
    output logic       data_e,
    output logic       ld_ac,
    output logic       wr
);

    localparam logic [2:0] INST_ADDR  = 3'd0;
    localparam logic [2:0] INST_FETCH = 3'd1;
    localparam logic [2:0] INST_LOAD  = 3'd2;
    localparam logic [2:0] IDLE       = 3'd3;
    localparam logic [2:0] OP_ADDR    = 3'd4;
    localparam logic [2:0] OP_FETCH   = 3'd5;
    localparam logic [2:0] ALU_OP     = 3'd6;
    localparam logic [2:0] STORE      = 3'd7;

    localparam logic [2:0] OP_HLT = 3'd0;
    localparam logic [2:0] OP_SKZ = 3'd1;
    localparam logic [2:0] OP_ADD = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_LDA = 3'd5;
    localparam logic [2:0] OP_STO = 3'd6;
    localparam logic [2:0] OP_JMP = 3'd7;

    // Last wait_cnt value before IDLE is left.
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    logic [2:0] phase;
    logic [3:0] wait_cnt;
    logic       halted;

    // NOTE: registered state uses non-blocking assignments so that every
    // flop samples the values from before the edge.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            phase    <= INST_ADDR;
            wait_cnt <= 4'd0;
            halted   <= 1'b0;
        end else if (halted) begin
`ifdef RISC_CONTROLLER_RESUME_EN
            // The HLT cycle has already pulsed inc_pc. Resuming goes
            // straight to operand fetch with no extra increment.
            if (resume) begin
                halted <= 1'b0;
                phase  <= OP_FETCH;
            end
`endif
        end else if (phase == OP_ADDR && opcode == OP_HLT) begin
            // Phase stays parked at OP_ADDR while halted.
            halted <= 1'b1;
        end else if (phase == IDLE) begin
            if (wait_cnt == WAIT_LAST) begin
                wait_cnt <= 4'd0;
                phase    <= OP_ADDR;
            end else begin
                wait_cnt <= wait_cnt + 4'd1;
            end
        end else begin
            // STORE + 1 wraps naturally to INST_ADDR in 3 bits.
            phase <= phase + 3'd1;
        end
    end

    logic alu_op;
    logic is_sto;
    logic is_jmp;

    assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);
    assign is_sto = (opcode == OP_STO);
    assign is_jmp = (opcode == OP_JMP);

    // NOTE: every output gets a default before the case so the decode
    // cannot infer a latch.
    always_comb begin
        sel    = 1'b0;
        rd     = 1'b0;
        ld_ir  = 1'b0;
        inc_pc = 1'b0;
        halt   = 1'b0;
        ld_pc  = 1'b0;
        data_e = 1'b0;
        ld_ac  = 1'b0;
        wr     = 1'b0;
        if (halted) begin
            halt = 1'b1;
        end else begin
            case (phase)
                INST_ADDR: sel = 1'b1;
                INST_FETCH: begin
                    sel = 1'b1;
                    rd  = 1'b1;
                end
                INST_LOAD, IDLE: begin
                    sel   = 1'b1;
                    rd    = 1'b1;
                    ld_ir = 1'b1;
                end
                OP_ADDR: begin
                    inc_pc = 1'b1;
                    halt   = (opcode == OP_HLT);
                end
                OP_FETCH: rd = alu_op;
                ALU_OP: begin
                    // A SKZ skip here plus the OP_ADDR increment gives PC+2.
                    // JMP never raises inc_pc, so ld_pc and inc_pc stay
                    // exclusive.
                    rd     = alu_op;
                    inc_pc = (opcode == OP_SKZ) && zero;
                    ld_pc  = is_jmp;
                    data_e = is_sto;
                end
                STORE: begin
                    rd     = alu_op;
                    ld_ac  = alu_op;
                    ld_pc  = is_jmp;
                    data_e = is_sto;
                    wr     = is_sto;
                end
                default: ;
            endcase
        end
    end

endmodule
